// File: rtl/symbol_decoder_core.sv
// Range-coder symbol decoder core. It runs a serial inverse-CDF search, then
// normalises rng/dif, then refills dif with bytes for one tile of coded data.
module symbol_decoder_core #(
   parameter int EC_MIN_PROB = 4,
   parameter int CDF_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_ready,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              nsyms_m1,
   input  logic [16*CDF_WIDTH-1:0] icdf_flat,
   output logic [3:0]              sym_out,
   output logic                    sym_valid,
   input  logic                    sym_ready,
   output logic [15:0]             rng_out
);

   // state   | meaning
   // UNINIT  | out of reset, waiting for init
   // FILL    | loading the first bytes of a tile into dif
   // IDLE    | waiting for a symbol request
   // SEARCH  | testing one inverse-CDF candidate per cycle
   // NORM    | renormalising rng/dif and updating cnt
   // REFILL  | topping up dif after cnt went negative
   // OUT     | holding sym_out until the consumer accepts it
   typedef enum logic [2:0] {
      S_UNINIT, S_FILL, S_IDLE, S_SEARCH, S_NORM, S_REFILL, S_OUT
   } state_t;

   localparam int PW = CDF_WIDTH + 2;

   state_t               state, state_nx;
   logic [15:0]          rng, u;
   logic [31:0]          dif;
   logic signed [5:0]    cnt;
   logic [3:0]           ret, n_q;
   logic [CDF_WIDTH-1:0] icdf_q [16];

   logic signed [6:0]    shift;
   logic                 fill_more;
   logic [31:0]          byte_shifted;
   logic [CDF_WIDTH-1:0] icdf_sel;
   logic [PW-1:0]        prod;
   logic [3:0]           rem;
   logic [15:0]          v;
   logic                 stop;
   logic [3:0]           d;
   logic signed [5:0]    cnt_norm;

   assign shift        = 7'sd8 - $signed({cnt[5], cnt});
   assign fill_more    = ~shift[6];
   assign byte_shifted = {24'd0, byte_in} << shift[4:0];
   assign icdf_sel     = icdf_q[ret];
   assign prod         = PW'(rng[15:8]) * PW'(icdf_sel[CDF_WIDTH-1:6]);
   assign rem          = n_q - ret;
   assign v            = 16'(prod >> 1) + 16'(EC_MIN_PROB) * {12'd0, rem};
   // Reaching the last symbol ends the search whatever the table says.
   assign stop         = (dif[31:16] >= v) || (ret == n_q);
   assign cnt_norm     = cnt - $signed({2'b00, d});

   always_comb begin
      d = 4'd15;
      for (int i = 0; i < 16; i++) begin
         if (rng[i]) d = 4'(15 - i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_UNINIT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      req_ready  = 1'b0;
      sym_valid  = 1'b0;
      case (state)
         S_UNINIT: ;
         S_FILL: begin
            byte_ready = fill_more;
            if (!fill_more) state_nx = S_IDLE;
         end
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = S_SEARCH;
         end
         S_SEARCH: if (stop) state_nx = S_NORM;
         S_NORM:   state_nx = cnt_norm[5] ? S_REFILL : S_OUT;
         S_REFILL: begin
            byte_ready = fill_more;
            if (!fill_more) state_nx = S_OUT;
         end
         S_OUT: begin
            sym_valid = 1'b1;
            if (sym_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_UNINIT;
      endcase
      if (init) state_nx = S_FILL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rng <= 16'h8000;
         dif <= 32'h7FFF_FFFF;
         cnt <= -6'sd15;
         ret <= '0;
         u   <= '0;
         n_q <= '0;
         for (int i = 0; i < 16; i++) icdf_q[i] <= '0;
      end else if (init) begin
         rng <= 16'h8000;
         dif <= 32'h7FFF_FFFF;
         cnt <= -6'sd15;
         ret <= '0;
      end else begin
         case (state)
            S_FILL, S_REFILL: begin
               if (fill_more && byte_valid) begin
                  dif <= dif ^ byte_shifted;
                  cnt <= cnt + 6'sd8;
               end
            end
            S_IDLE: begin
               if (req_valid) begin
                  n_q <= nsyms_m1;
                  for (int i = 0; i < 16; i++) icdf_q[i] <= icdf_flat[i*CDF_WIDTH +: CDF_WIDTH];
                  u   <= rng;
                  ret <= '0;
               end
            end
            S_SEARCH: begin
               if (stop) begin
                  rng <= u - v;
                  dif <= dif - {v, 16'd0};
               end else begin
                  u   <= v;
                  ret <= ret + 4'd1;
               end
            end
            S_NORM: begin
               rng <= rng << d;
               dif <= ((dif + 32'd1) << d) - 32'd1;
               cnt <= cnt_norm;
            end
            default: ;
         endcase
      end
   end

   assign sym_out = ret;
   assign rng_out = rng;

endmodule

// File: tb/tb_symbol_decoder_core.sv
// Bench for symbol_decoder_core. It uses a vector table for known symbols and a
// reference model with a scoreboard for random streams, stalls, abort and reset.
module tb_symbol_decoder_core;

   logic         clk = 1'b0;
   logic         reset, init;
   logic [7:0]   byte_in;
   logic         byte_valid, byte_ready;
   logic         req_valid, req_ready;
   logic [3:0]   nsyms_m1;
   logic [255:0] icdf_flat;
   logic [3:0]   sym_out;
   logic         sym_valid, sym_ready;
   logic [15:0]  rng_out;

   symbol_decoder_core dut (
      .clk(clk), .reset(reset), .init(init),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .req_valid(req_valid), .req_ready(req_ready),
      .nsyms_m1(nsyms_m1), .icdf_flat(icdf_flat),
      .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .rng_out(rng_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  sym;
      logic [15:0] rng;
      int          idx;
   } exp_t;

   typedef struct packed {
      logic [7:0]       b;
      logic [3:0]       n;
      logic [3:0][15:0] ic;
      logic [3:0]       esym;
      logic [15:0]      erng;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  stream [0:1023];
   int          dut_idx, m_idx, m_rng, m_cnt, n_stalls;
   logic [31:0] m_dif;
   logic [3:0]  last_sym;
   logic [15:0] last_rng;
   exp_t        sb [$];
   vec_t        vecs [4];
   int          ic [16];
   int          desc_ic [16];
   int          lat;
   bit          ab, rst_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gb(input int i);
      return (i < 1024) ? stream[i] : 8'h00;
   endfunction

   function automatic logic [255:0] pack(input int t [16]);
      logic [255:0] f = '0;
      for (int i = 0; i < 16; i++) f[16*i +: 16] = 16'(t[i]);
      return f;
   endfunction

   task automatic tick();
      bit hs;
      hs = byte_valid && byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs) dut_idx++;
      byte_in = gb(dut_idx);
   endtask

   task automatic m_fill();
      while (8 - m_cnt >= 0) begin
         m_dif = m_dif ^ (32'(gb(m_idx)) << (8 - m_cnt));
         m_idx++;
         m_cnt += 8;
      end
   endtask

   task automatic m_init();
      m_rng = 32768; m_dif = 32'h7FFF_FFFF; m_cnt = -15; m_idx = 0;
      m_fill();
   endtask

   task automatic m_decode(input int n, input int t [16], output exp_t e);
      int u, v, k, d;
      u = m_rng; k = 0;
      forever begin
         v = (((m_rng >> 8) * (t[k] >> 6)) >> 1) + 4 * (n - k);
         if (int'(m_dif[31:16]) >= v || k == n) break;
         u = v; k++;
      end
      m_rng = u - v;
      m_dif = m_dif - (32'(v) << 16);
      d = 0;
      while (d < 15 && m_rng < 32768) begin m_rng = m_rng * 2; d++; end
      m_dif = ((m_dif + 32'd1) << d) - 32'd1;
      m_cnt -= d;
      if (m_cnt < 0) m_fill();
      e.sym = 4'(k); e.rng = 16'(m_rng); e.idx = m_idx;
   endtask

   task automatic do_init();
      init = 1'b1; byte_valid = 1'b0;
      tick();
      init = 1'b0; dut_idx = 0; byte_in = gb(0); byte_valid = 1'b1;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 100 && !req_ready; t++) tick();
      chk("fill_done", 32'(req_ready), 32'd1);
   endtask

   // mode 0: plain, 1: withhold bytes 5 cycles in refill, 2: async reset in refill
   task automatic decode(input int n, input int t [16], input int mode, input int bp,
                         output int lt, output bit aborted);
      exp_t e, g;
      bit stalled, done;
      logic [15:0] r0;
      logic [3:0] s0;
      aborted = 1'b0; lt = 0; stalled = 1'b0; done = 1'b0;
      m_decode(n, t, e);
      sb.push_back(e);
      nsyms_m1 = 4'(n); icdf_flat = pack(t); req_valid = 1'b1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (sym_valid) begin done = 1'b1; break; end
         if (byte_ready && mode != 0 && !stalled) begin
            stalled = 1'b1; byte_valid = 1'b0; r0 = rng_out;
            if (mode == 2) begin
               tick();
               #2 reset = 1'b0;
               #1;
               chk("rst_byte_ready", 32'(byte_ready), 32'd0);
               chk("rst_req_ready", 32'(req_ready), 32'd0);
               chk("rst_sym_valid", 32'(sym_valid), 32'd0);
               chk("rst_sym_out", 32'(sym_out), 32'd0);
               chk("rst_rng", 32'(rng_out), 32'h8000);
               sb.delete();
               aborted = 1'b1;
               return;
            end
            repeat (5) tick();
            chk("stall_rng", 32'(rng_out), 32'(r0));
            chk("stall_byte_ready", 32'(byte_ready), 32'd1);
            n_stalls++;
            byte_valid = 1'b1;
         end
         tick();
         lt++;
      end
      if (!done) begin
         chk("sym_timeout", 32'(sym_valid), 32'd1);
         sb.delete();
         return;
      end
      if (bp > 0) begin
         sym_ready = 1'b0; s0 = sym_out; r0 = rng_out;
         repeat (bp) tick();
         chk("bp_valid", 32'(sym_valid), 32'd1);
         chk("bp_sym", 32'(sym_out), 32'(s0));
         chk("bp_rng", 32'(rng_out), 32'(r0));
      end
      g = sb.pop_front();
      last_sym = sym_out; last_rng = rng_out;
      chk("sb_sym", 32'(sym_out), 32'(g.sym));
      chk("sb_rng", 32'(rng_out), 32'(g.rng));
      chk("sb_bytes", dut_idx, g.idx);
      chk("rng_normalised", 32'(rng_out[15]), 32'd1);
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
      chk("next_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{b: 8'h00, n: 4'd1, ic: {16'd0, 16'd0, 16'd0, 16'd16384},
                  esym: 4'd0, erng: 16'd65520};
      vecs[1] = '{b: 8'hFF, n: 4'd1, ic: {16'd0, 16'd0, 16'd0, 16'd16384},
                  esym: 4'd1, erng: 16'd32776};
      vecs[2] = '{b: 8'hFF, n: 4'd3, ic: {16'd0, 16'd8000, 16'd16000, 16'd24000},
                  esym: 4'd3, erng: 16'd64032};
      vecs[3] = '{b: 8'h00, n: 4'd3, ic: {16'd0, 16'd100, 16'd30000, 16'd32768},
                  esym: 4'd1, erng: 16'd45120};
      for (int i = 0; i < 16; i++) desc_ic[i] = 32000 - i * 2100;

      reset = 1'b0; init = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      req_valid = 1'b0; nsyms_m1 = 4'd0; icdf_flat = '0; sym_ready = 1'b0;
      dut_idx = 0; n_stalls = 0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_byte_ready", 32'(byte_ready), 32'd0);
      chk("reset_sym_valid", 32'(sym_valid), 32'd0);
      chk("reset_sym_out", 32'(sym_out), 32'd0);
      chk("reset_rng", 32'(rng_out), 32'h8000);
      reset = 1'b1;

      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 1024; j++) stream[j] = vecs[k].b;
         for (int j = 0; j < 16; j++) ic[j] = (j < 4) ? int'(vecs[k].ic[j]) : 0;
         do_init(); m_init(); wait_idle();
         chk("fill_bytes", dut_idx, 3);
         decode(int'(vecs[k].n), ic, 0, 0, lat, ab);
         chk("tbl_sym", 32'(last_sym), 32'(vecs[k].esym));
         chk("tbl_rng", 32'(last_rng), 32'(vecs[k].erng));
         chk("tbl_latency", lat, int'(vecs[k].esym) + 2);
      end

      // Abort a long search with init, then confirm a clean restart.
      for (int j = 0; j < 1024; j++) stream[j] = 8'hFF;
      do_init(); m_init(); wait_idle();
      nsyms_m1 = 4'd15; icdf_flat = pack(desc_ic); req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      chk("search_no_valid", 32'(sym_valid), 32'd0);
      do_init();
      chk("abort_rng", 32'(rng_out), 32'h8000);
      chk("abort_sym_valid", 32'(sym_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      chk("abort_byte_ready", 32'(byte_ready), 32'd1);
      m_init(); wait_idle();
      chk("abort_fill_bytes", dut_idx, 3);
      decode(15, desc_ic, 0, 0, lat, ab);
      chk("abort_recover_sym", 32'(last_sym), 32'd15);
      chk("abort_recover_lat", lat, 17);

      // Random stream: refills, byte stalls and output backpressure.
      for (int j = 0; j < 1024; j++) stream[j] = 8'($urandom_range(0, 255));
      do_init(); m_init(); wait_idle();
      for (int i = 0; i < 40; i++)
         decode(15, desc_ic, (i % 5 == 1) ? 1 : 0, (i == 3 || i == 17) ? 4 : 0, lat, ab);
      chk("stalls_seen", 32'(n_stalls > 0), 32'd1);

      rst_done = 1'b0;
      for (int i = 0; i < 40 && !rst_done; i++) decode(15, desc_ic, 2, 0, lat, rst_done);
      chk("reset_in_refill", 32'(rst_done), 32'd1);
      @(negedge clk);
      reset = 1'b1; byte_valid = 1'b1; req_valid = 1'b1;
      repeat (3) tick();
      chk("uninit_req_ready", 32'(req_ready), 32'd0);
      chk("uninit_byte_ready", 32'(byte_ready), 32'd0);
      req_valid = 1'b0;
      do_init(); m_init(); wait_idle();
      decode(15, desc_ic, 0, 0, lat, ab);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/symbol_decoder_core.md
SYMBOL_DECODER_CORE -- requirements
Module: symbol_decoder_core

Interface
REQ-001 Parameter: EC_MIN_PROB, 4, per-symbol minimum probability weight added in the threshold calculation.
REQ-002 Parameter: CDF_WIDTH, 16, width of one inverse-CDF entry (Q15 value in 16 bits).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 init  input  1  one-cycle pulse that starts a new tile and clears all decoder state.
REQ-006 byte_in  input  8  next compressed byte.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  decoder consumes byte_in this cycle when byte_valid is high.
REQ-009 req_valid  input  1  a symbol decode request is presented.
REQ-010 req_ready  output  1  request accepted on req_valid & req_ready.
REQ-011 nsyms_m1  input  4  N = symbol count minus 1 (1..15).
REQ-012 icdf_flat  input  256  icdf[i] = icdf_flat[16i+15:16i], i = 0..15; sampled on acceptance.
REQ-013 sym_out  output  4  decoded symbol index.
REQ-014 sym_valid  output  1  sym_out is valid; held until accepted.
REQ-015 sym_ready  input  1  consumer accepts sym_out.
REQ-016 rng_out  output  16  current range register, for debug and verification.

Function
REQ-017 State: rng 16 bits, dif 32 bits (WSIZE = 32), cnt signed 6 bits, FSM in {UNINIT, FILL, IDLE, SEARCH, NORM, REFILL, OUT}.
REQ-018 UNINIT: the FSM waits for init; req_ready = 0 and byte_ready = 0.
REQ-019 init, accepted in any state: rng = 0x8000, dif = 0x7FFFFFFF, cnt = -15, ret = 0, sym_valid = 0; FSM enters FILL; any in-flight symbol is discarded.
REQ-020 FILL/REFILL: the byte shift is s = 8 - cnt.
REQ-021 FILL/REFILL: while s >= 0, byte_ready = 1 and each handshake performs dif ^= byte_in << s and cnt += 8, at one byte per cycle.
REQ-022 FILL/REFILL exit: when s < 0, FILL exits to IDLE and REFILL exits to OUT.
REQ-023 Byte stall: if byte_valid is low, the FSM waits with no state change and no timeout.
REQ-024 IDLE: req_ready = 1; on acceptance, latch N and icdf, set u = v = rng and ret = 0, then enter SEARCH.
REQ-025 SEARCH: one candidate per cycle, computing v = (((rng >> 8) * (icdf[ret] >> 6)) >> 1) + EC_MIN_PROB * (N - ret).
REQ-026 SEARCH: the product is 8 x 10 bits to 18 bits, and the final v fits 16 bits.
REQ-027 SEARCH: c = dif[31:16]; if c >= v or ret == N, stop with the symbol = ret; otherwise u = v, ret += 1, and continue.
REQ-028 SEARCH: the termination at ret == N is forced regardless of the icdf contents.
REQ-029 SEARCH latency: symbol k takes k+1 cycles.
REQ-030 On stop: rng = u - v (u is the previous v, or the old rng when ret = 0), and dif -= v << 16.
REQ-031 NORM (1 cycle): d = 15 - msb_index(rng), range 0..13; rng <<= d; dif = ((dif + 1) << d) - 1, truncated to 32 bits; cnt -= d.
REQ-032 NORM exit: if cnt < 0, enter REFILL; otherwise enter OUT.
REQ-033 OUT: sym_valid = 1 with sym_out stable until sym_ready; on the handshake, return to IDLE.
REQ-034 OUT throughput: back-to-back symbols are allowed; the next req is accepted the cycle after the OUT handshake.
REQ-035 Stalls: req_valid low in IDLE and sym_ready low in OUT both stall without state change.
REQ-036 Invariant: after NORM, rng is in [0x8000, 0xFFFF].

Reset
REQ-037 On reset assertion, at any time including mid-SEARCH or mid-REFILL: FSM = UNINIT, rng = 0x8000, dif = 0x7FFFFFFF, cnt = -15, sym_out = 0, sym_valid = 0, req_ready = 0, byte_ready = 0, rng_out = 0x8000.
REQ-038 After reset deassertion, an init is required before any bytes or requests are accepted.

Verification
REQ-039 Init fill: init, then bytes 00,00,00 -> exactly 3 bytes accepted at s = 23, 15, 7; final cnt = 9, dif = 0x7FFFFFFF; FSM returns to IDLE.
REQ-040 Symbol 0: after REQ-039, N = 1, icdf = {16384, 0} -> v = 16388, sym_out = 0 after 1 SEARCH cycle; rng = 65520, dif = 0xFFEFFFFF, cnt = 7, no refill.
REQ-041 Symbol 1: init plus bytes FF,FF,FF (dif = 0x0000007F), same request -> sym_out = 1 after 2 SEARCH cycles; rng = 32776, dif = 0x000000FF, cnt = 8.
REQ-042 Refill and stall: drive cnt negative via repeated small-probability symbols (N = 15, icdf = 32000 descending) with byte_valid withheld 5 cycles -> FSM holds in REFILL with no dif change; bytes are then consumed until s < 0; rng is always >= 0x8000 at OUT.
REQ-043 Backpressure and abort: hold sym_ready low 4 cycles -> sym_out stays stable; then assert init mid-SEARCH -> sym_valid stays 0 and the state matches REQ-019.
REQ-044 Async reset: assert reset mid-REFILL between clock edges -> all outputs reach reset values immediately, with no byte handshake.
